// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts a Q8.24 rectangular sample to
// magnitude and phase over 24 micro-rotations, one per clock.
module cordic_vector (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] x_re,
    input  logic signed [31:0] x_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] mag_out,
    output logic signed [31:0] phase_out
);

    localparam logic signed [31:0] HALF_PI   = 32'sh01921FB5;
    localparam logic signed [63:0] K_GAIN    = 64'sd10188015;
    localparam logic        [4:0]  LAST_ITER = 5'd24;

    typedef enum logic [1:0] {IDLE, ITER, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic        [4:0]  iter;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
    logic               zero_flag;
    logic signed [31:0] x_shift;
    logic signed [31:0] y_shift;
    logic signed [31:0] angle;
    logic signed [31:0] mag_scaled;

    // atan(2^-i) in Q8.24, rounded to nearest
    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'sd13176795;
            5'd1:    atan_lut = 32'sd7778716;
            5'd2:    atan_lut = 32'sd4110060;
            5'd3:    atan_lut = 32'sd2086331;
            5'd4:    atan_lut = 32'sd1047214;
            5'd5:    atan_lut = 32'sd524117;
            5'd6:    atan_lut = 32'sd262123;
            5'd7:    atan_lut = 32'sd131069;
            5'd8:    atan_lut = 32'sd65536;
            5'd9:    atan_lut = 32'sd32768;
            5'd10:   atan_lut = 32'sd16384;
            5'd11:   atan_lut = 32'sd8192;
            5'd12:   atan_lut = 32'sd4096;
            5'd13:   atan_lut = 32'sd2048;
            5'd14:   atan_lut = 32'sd1024;
            5'd15:   atan_lut = 32'sd512;
            5'd16:   atan_lut = 32'sd256;
            5'd17:   atan_lut = 32'sd128;
            5'd18:   atan_lut = 32'sd64;
            5'd19:   atan_lut = 32'sd32;
            5'd20:   atan_lut = 32'sd16;
            5'd21:   atan_lut = 32'sd8;
            5'd22:   atan_lut = 32'sd4;
            5'd23:   atan_lut = 32'sd2;
            default: atan_lut = 32'sd0;
        endcase
    endfunction

    assign x_shift    = x >>> iter;
    assign y_shift    = y >>> iter;
    assign angle      = atan_lut(iter);
    // bits [55:24] of the 64-bit gain product
    assign mag_scaled = 32'((64'(x) * K_GAIN) >>> 24);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (iter == LAST_ITER) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pre-rotation into the right half-plane keeps CORDIC within its convergence range
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iter      <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            zero_flag <= 1'b0;
            out_valid <= 1'b0;
            mag_out   <= '0;
            phase_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        iter      <= '0;
                        zero_flag <= (x_re == 32'sd0) && (x_im == 32'sd0);
                        if (!x_re[31]) begin
                            x <= x_re;
                            y <= x_im;
                            z <= '0;
                        end else if (!x_im[31]) begin
                            x <= x_im;
                            y <= -x_re;
                            z <= HALF_PI;
                        end else begin
                            x <= -x_im;
                            y <= x_re;
                            z <= -HALF_PI;
                        end
                    end
                end
                ITER: begin
                    if (iter == LAST_ITER) begin
                        mag_out   <= zero_flag ? 32'sd0 : mag_scaled;
                        phase_out <= zero_flag ? 32'sd0 : z;
                        out_valid <= 1'b1;
                    end else begin
                        if (!y[31]) begin
                            x <= x + y_shift;
                            y <= y - x_shift;
                            z <= z + angle;
                        end else begin
                            x <= x - y_shift;
                            y <= y + x_shift;
                            z <= z - angle;
                        end
                        iter <= iter + 5'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: expected polar results come from
// real-valued sqrt/atan2 and are checked as the DUT presents them.
module tb_cordic_vector;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] x_re;
    logic signed [31:0] x_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] mag_out;
    logic signed [31:0] phase_out;

    typedef struct {
        int     mag;
        int     ph;
        int     tol_mag;
        int     tol_ph;
        longint acc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   cur_exp;
    int     checks = 0;
    int     errors = 0;
    int     cur_tol_mag = 16;
    int     cur_tol_ph = 16;
    longint cyc = 0;
    bit     out_seen = 1'b0;

    always #5 clk = ~clk;

    cordic_vector dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .phase_out (phase_out)
    );

    task automatic checkOutput(input string name, input longint actual,
                               input longint expected, input longint tol);
        longint d;
        d = actual - expected;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, expected %0d (tol %0d)",
                     name, actual, expected, tol);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, actual none, expected event", name);
    endtask

    // Ideal polar conversion of the sampled Q8.24 inputs
    function automatic exp_t refModel(input logic signed [31:0] re,
                                      input logic signed [31:0] im);
        exp_t e;
        real  rr;
        real  ii;
        rr = $itor(re) / 16777216.0;
        ii = $itor(im) / 16777216.0;
        if (re == 0 && im == 0) begin
            e.mag = 0;
            e.ph  = 0;
        end else begin
            e.mag = int'($sqrt(rr * rr + ii * ii) * 16777216.0);
            e.ph  = int'($atan2(ii, rr) * 16777216.0);
        end
        e.tol_mag = cur_tol_mag;
        e.tol_ph  = cur_tol_ph;
        e.acc     = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_t e;
            e     = refModel(x_re, x_im);
            e.acc = cyc;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            out_seen = 1'b0;
        end else begin
            if (out_valid && !out_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: actual mag %0d phase %0d, expected no result",
                             mag_out, phase_out);
                end else begin
                    cur_exp = exp_q.pop_front();
                    checkOutput("latency", cyc - 1 - cur_exp.acc, 25, 0);
                    checkOutput("mag", mag_out, cur_exp.mag, cur_exp.tol_mag);
                    checkOutput("phase", phase_out, cur_exp.ph, cur_exp.tol_ph);
                end
            end else if (out_valid) begin
                checkOutput("hold_mag", mag_out, cur_exp.mag, cur_exp.tol_mag);
                checkOutput("hold_phase", phase_out, cur_exp.ph, cur_exp.tol_ph);
            end
            out_seen = out_valid;
        end
    end

    task automatic applyStimulus(input logic signed [31:0] re, input logic signed [31:0] im,
                                 input int tm, input int tp);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeoutFail("in_ready");
            return;
        end
        cur_tol_mag = tm;
        cur_tol_ph  = tp;
        x_re        = re;
        x_im        = im;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) timeoutFail("result");
    endtask

    task automatic waitOutValid();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeoutFail("out_valid");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic signed [31:0] re;
        logic signed [31:0] im;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_re      = '0;
        x_im      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1, 0);
        checkOutput("reset_out_valid", out_valid, 0, 0);
        checkOutput("reset_mag", mag_out, 0, 0);
        checkOutput("reset_phase", phase_out, 0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'sh01000000, 32'sh00000000, 16, 16);
        waitIdle();
        applyStimulus(32'sh00000000, 32'sh01000000, 16, 16);
        waitIdle();
        applyStimulus(32'shFF000000, 32'sh00000000, 16, 16);
        waitIdle();
        applyStimulus(32'shFF000000, 32'shFFFFFFF0, 16, 32);
        waitIdle();
        applyStimulus(32'sh03000000, 32'sh04000000, 16, 16);
        waitIdle();

        // Result held against back-pressure while new input is offered
        out_ready = 1'b0;
        applyStimulus(32'sh02000000, 32'sh01000000, 16, 16);
        waitOutValid();
        cur_tol_mag = 16;
        cur_tol_ph  = 16;
        x_re        = 32'sh02000000;
        x_im        = 32'shFF000000;
        in_valid    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", in_ready, 0, 0);
            checkOutput("hold_out_valid", out_valid, 1, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("consume_out_valid", out_valid, 0, 0);
        checkOutput("consume_in_ready", in_ready, 1, 0);
        @(negedge clk);
        checkOutput("accept_after_consume", in_ready, 0, 0);
        in_valid = 1'b0;
        waitIdle();

        // Abort mid-iteration
        applyStimulus(32'sh01000000, 32'sh01000000, 16, 16);
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0, 0);
        checkOutput("abort_in_ready", in_ready, 1, 0);
        checkOutput("abort_mag", mag_out, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", in_ready, 1, 0);
        checkOutput("release_out_valid", out_valid, 0, 0);
        repeat (30) @(negedge clk);
        applyStimulus(32'sh00000000, 32'sh00000000, 0, 0);
        waitIdle();

        for (int n = 0; n < 20; n++) begin
            do begin
                re = 32'(int'($urandom_range(0, 32'h08000000)) - 32'sh04000000);
                im = 32'(int'($urandom_range(0, 32'h08000000)) - 32'sh04000000);
            end while ((re < 32'sh02000000 && re > -32'sh02000000) &&
                       (im < 32'sh02000000 && im > -32'sh02000000));
            applyStimulus(re, im, 16, 16);
            waitIdle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset_n`: input, 1 bit, asynchronous, active-low reset.
REQ-003 The block SHALL have the port `in_valid`: input, 1 bit, meaning a rectangular sample is presented.
REQ-004 The block SHALL have the port `in_ready`: output, 1 bit, meaning the block can accept a sample.
REQ-005 The block SHALL have the ports `x_re` and `x_im`: inputs, signed 32 bits each, the real and imaginary parts, Q8.24.
REQ-006 The block SHALL have the port `out_valid`: output, 1 bit, meaning the polar result is valid.
REQ-007 The block SHALL have the port `out_ready`: input, 1 bit, meaning the downstream consumer accepts the result.
REQ-008 The block SHALL have the port `mag_out`: output, signed 32 bits, the magnitude, Q8.24, always >= 0.
REQ-009 The block SHALL have the port `phase_out`: output, signed 32 bits, the angle in radians, Q8.24, in the range (-pi, pi].

Function
REQ-010 The block SHALL be an iterative vectoring-mode CORDIC, the inverse of the team's rotation-mode CORDIC: (x_re, x_im) -> (|x|, atan2(x_im, x_re)).
REQ-011 The FSM SHALL have states IDLE, ITER and HOLD; `in_ready` = 1 only in IDLE.
REQ-012 On the accept edge (`in_valid` & `in_ready` in IDLE), the block SHALL capture pre-rotated x, y, z and go to ITER with the iteration counter i = 0:
- x_re >= 0: x = x_re, y = x_im, z = 0.
- x_re < 0 and x_im >= 0: x = x_im, y = -x_re, z = +pi/2 (0x01921FB5).
- x_re < 0 and x_im < 0: x = -x_im, y = x_re, z = -pi/2.
REQ-013 In ITER, each edge SHALL perform one micro-rotation for i = 0..23, using arithmetic right shifts:
- If y >= 0: x += y>>>i, y -= x>>>i, z += atan(2^-i).
- Otherwise: x -= y>>>i, y += x>>>i, z -= atan(2^-i).
- All updates use the old values of x, y and z.
REQ-014 The atan LUT SHALL hold 24 entries, Q8.24, rounded to nearest; entry 0 = 0x00C90FDB (pi/4).
REQ-015 On the edge after i = 23, the block SHALL register `mag_out` = bits [55:24] of the 64-bit signed product x*K, where K = 10188015 (0.607253 in Q8.24).
REQ-016 On that same edge, the block SHALL register `phase_out` = z, set `out_valid` = 1, and go to HOLD.
REQ-017 Latency SHALL be exactly 25 rising edges from the accept edge to the edge that sets `out_valid`; throughput SHALL be at most one sample per 26 cycles.
REQ-018 In HOLD, `mag_out`, `phase_out` and `out_valid` SHALL stay stable until `out_valid` & `out_ready`.
REQ-019 On the HOLD consume edge, the block SHALL clear `out_valid` and return to IDLE; a new sample is accepted no earlier than the following edge.
REQ-020 `out_ready` SHALL be ignored outside HOLD, and `in_valid` SHALL be ignored outside IDLE; input values are sampled only on the accept edge.
REQ-021 If x_re = x_im = 0 on accept, the result SHALL be `mag_out` = 0 and `phase_out` = 0 with identical latency (zero flag captured at accept).
REQ-022 Results SHALL be accurate to ±16 LSB in both outputs for |x_re|, |x_im| < 32.0 (0x20000000).
REQ-023 Outside that input range, internal arithmetic SHALL wrap in two's complement with no saturation; results are undefined but the FSM and handshake remain correct.
REQ-024 x_re < 0 with x_im = 0 SHALL yield a phase of approximately +pi, never -pi.

Reset
REQ-025 While `reset_n` = 0, the block SHALL force state IDLE, i = 0, x = y = z = 0, `out_valid` = 0, `mag_out` = 0 and `phase_out` = 0, independent of `clk`.
REQ-026 Reset asserted mid-ITER or in HOLD SHALL abort the transaction with no output; after release, `in_ready` = 1 on the first cycle.
REQ-027 Reset release SHALL be synchronised externally; the block requires no idle cycles after release.

Verification
REQ-028 The bench SHALL drive (0x01000000, 0) -> `mag_out` = 0x01000000 ±16 and `phase_out` = 0 ±16, with `out_valid` exactly 25 edges after accept.
REQ-029 The bench SHALL drive (0, 0x01000000) -> `mag_out` = 0x01000000 ±16 and `phase_out` = 0x01921FB5 ±16.
REQ-030 The bench SHALL drive (0xFF000000, 0) -> `phase_out` = 0x03243F6B ±16.
REQ-031 The bench SHALL drive (0xFF000000, 0xFFFFFFF0) -> `phase_out` ≈ -0x03243F6B ±32.
REQ-032 The bench SHALL drive (0x03000000, 0x04000000) -> `mag_out` = 0x05000000 ±16 and `phase_out` = 15557423 (0.927295 rad) ±16.
REQ-033 The bench SHALL hold `out_ready` = 0 for 10 cycles in HOLD -> outputs stable, `in_ready` = 0 and `in_valid` ignored; then release -> consume, next sample accepted one edge later.
REQ-034 The bench SHALL pulse `reset_n` low at i = 12 -> `out_valid` stays 0 and `in_ready` = 1 after release; then drive (0, 0) -> `mag_out` = 0 and `phase_out` = 0 after 25 edges.
